// File: rtl/bpm_calculator.sv
// bpm_calculator: measures peak-to-peak intervals in valid samples and converts them to
// beats per minute (60*FS/interval) with a one-bit-per-clock restoring divider.
// Optional feature macro: BPM_AVG4_EN (divide by the mean of the last four intervals).
module bpm_calculator #(
    parameter int FS           = 100,
    parameter int CNT_W        = 12,
    parameter int BPM_W        = 8,
    parameter int MIN_INTERVAL = 25,
    parameter int MAX_INTERVAL = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             peak_in,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             busy,
    output logic             timeout,
    output logic             overrun
);
    localparam int NUM     = 60 * FS;
    localparam int DIV_W   = $clog2(NUM + 1);
    localparam int ITER_W  = $clog2(DIV_W + 1);
    localparam int BPM_MAX = (1 << BPM_W) - 1;

    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_INTERVAL);
    localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INTERVAL);
    localparam logic [DIV_W-1:0]  NUM_V     = DIV_W'(NUM);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(DIV_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DIV   = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   divisor_r;
    logic [CNT_W-1:0]   rem_r;
    logic [DIV_W-1:0]   quo_r;
    logic [ITER_W-1:0]  iter_r;
    logic               to_pend_r;
    logic [BPM_W-1:0]   bpm_r;
    logic               bpm_valid_r;
    logic               busy_r;
    logic               timeout_r;
    logic               overrun_r;

    logic               sample_s;
    logic               peak_s;
    logic [CNT_W-1:0]   interval_s;
    logic               qualify_s;
    logic               tmo_s;
    logic [CNT_W-1:0]   divisor_in_s;
    logic               hist_full_s;
    logic [CNT_W:0]     shift_s;
    logic               q_bit_s;
    logic [CNT_W-1:0]   rem_next_s;
    logic [BPM_W-1:0]   bpm_s;

    assign sample_s   = valid_in & en;
    assign peak_s     = sample_s & peak_in;
    assign interval_s = cnt_r + CNT_W'(1);
    // A saturated counter means the interval is already past timeout, so it is never measured.
    assign qualify_s  = peak_s && (state_r != ST_IDLE) && (interval_s >= MIN_CNT) && (cnt_r != MAX_CNT);
    assign tmo_s      = en && (cnt_r == MAX_CNT);

`ifdef BPM_AVG4_EN
    logic [CNT_W-1:0] hist_r [3];
    logic [1:0]       hist_n_r;
    logic [CNT_W+1:0] sum_s;

    // The three stored intervals plus the new one form the four-entry averaging window.
    assign sum_s        = (CNT_W+2)'(interval_s) + (CNT_W+2)'(hist_r[0])
                        + (CNT_W+2)'(hist_r[1]) + (CNT_W+2)'(hist_r[2]);
    assign divisor_in_s = CNT_W'(sum_s >> 2);
    assign hist_full_s  = (hist_n_r == 2'd3);

    // History shift register; flushed whenever the FSM sits in IDLE.
    always_ff @(posedge clk) begin
        if (rst || state_r == ST_IDLE) begin
            hist_r[0] <= {CNT_W{1'b0}};
            hist_r[1] <= {CNT_W{1'b0}};
            hist_r[2] <= {CNT_W{1'b0}};
            hist_n_r  <= 2'd0;
        end else if (state_r == ST_ARMED && qualify_s) begin
            hist_r[0] <= interval_s;
            hist_r[1] <= hist_r[0];
            hist_r[2] <= hist_r[1];
            hist_n_r  <= hist_full_s ? hist_n_r : hist_n_r + 2'd1;
        end else begin
            hist_n_r  <= hist_n_r;
        end
    end
`else
    assign divisor_in_s = interval_s;
    assign hist_full_s  = 1'b1;
`endif

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shift_s = {rem_r, quo_r[DIV_W-1]};
        if (shift_s >= {1'b0, divisor_r}) begin
            q_bit_s    = 1'b1;
            rem_next_s = CNT_W'(shift_s - {1'b0, divisor_r});
        end else begin
            q_bit_s    = 1'b0;
            rem_next_s = shift_s[CNT_W-1:0];
        end
    end

    // Quotient saturation to the output width.
    always_comb begin
        if (int'(quo_r) > BPM_MAX) begin
            bpm_s = {BPM_W{1'b1}};
        end else begin
            bpm_s = BPM_W'(quo_r);
        end
    end

    // Interval counter, control FSM, divider datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            divisor_r   <= {CNT_W{1'b0}};
            rem_r       <= {CNT_W{1'b0}};
            quo_r       <= {DIV_W{1'b0}};
            iter_r      <= {ITER_W{1'b0}};
            to_pend_r   <= 1'b0;
            bpm_r       <= {BPM_W{1'b0}};
            bpm_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            bpm_valid_r <= 1'b0;
            overrun_r   <= 1'b0;

            if (sample_s) begin
                if (peak_s && (state_r == ST_IDLE || qualify_s)) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (cnt_r != MAX_CNT) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end else begin
                    cnt_r <= cnt_r;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (peak_s) begin
                        state_r <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (tmo_s) begin
                        state_r   <= ST_IDLE;
                        timeout_r <= 1'b1;
                        bpm_r     <= {BPM_W{1'b0}};
                    end else if (qualify_s && hist_full_s) begin
                        state_r   <= ST_DIV;
                        divisor_r <= divisor_in_s;
                        rem_r     <= {CNT_W{1'b0}};
                        quo_r     <= NUM_V;
                        iter_r    <= {ITER_W{1'b0}};
                        to_pend_r <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ST_DIV: begin
                    if (qualify_s) begin
                        overrun_r <= 1'b1;
                    end
                    if (tmo_s) begin
                        to_pend_r <= 1'b1;
                    end
                    if (iter_r != LAST_ITER) begin
                        rem_r  <= rem_next_s;
                        quo_r  <= {quo_r[DIV_W-2:0], q_bit_s};
                        iter_r <= iter_r + ITER_W'(1);
                    end else begin
                        // A timeout seen during the divide re-asserts after this update clears it.
                        bpm_r       <= bpm_s;
                        bpm_valid_r <= 1'b1;
                        busy_r      <= 1'b0;
                        timeout_r   <= to_pend_r | tmo_s;
                        state_r     <= (to_pend_r | tmo_s) ? ST_IDLE : ST_ARMED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bpm       = bpm_r;
    assign bpm_valid = bpm_valid_r;
    assign busy      = busy_r;
    assign timeout   = timeout_r;
    assign overrun   = overrun_r;

endmodule
